bisr_remap_ctrl: RTL and testbench
==================================

BISR_REMAP_CTRL -- requirements
Module: bisr_remap_ctrl

Interface
REQ-001 SHALL provide parameter ADDR_W, default 16, width of host and fault addresses.
REQ-002 SHALL provide parameter DATA_W, default 8, width of host write data.
REQ-003 SHALL provide parameter NUM_SPARE, default 32, number of spare rows and fault-table entries; legal range 2..1024. SW = clog2(NUM_SPARE), CW = clog2(NUM_SPARE+1).
REQ-004 SHALL have ports (name, direction, width, meaning):
 CLK  in  1  single clock, all state on rising edge.
 RST  in  1  reset; one clock, reset is asynchronous and active-high.
 BIST_EN  in  1  learn window; high while BIST reports faults.
 FLT_VALID  in  1  fault report valid.
 FLT_ADDR  in  ADDR_W  faulty host address.
 FLT_READY  out  1  fault report accepted when high with FLT_VALID.
 CLEAR  in  1  synchronous fault-table wipe.
 CSB  in  1  host chip select, active-low.
 WEB  in  1  host write enable, active-low.
 ADDR  in  ADDR_W  host address.
 IDATA  in  DATA_W  host write data.
 BISR_EN  out  1  registered hit; main-array data must be replaced by spare.
 SPARE_CSB  out  1  spare array select, active-low.
 SPARE_WEB  out  1  spare array write enable, active-low.
 SPARE_ADDR  out  SW  spare row index.
 SPARE_IDATA  out  DATA_W  spare write data.
 FAULT_COUNT  out  CW  number of valid table entries.
 REPAIR_FAIL  out  1  sticky: more unique faults than spares.

Function
REQ-005 SHALL hold a table of NUM_SPARE entries {valid, ADDR_W address}; entry index i is permanently bound to spare row i.
REQ-006 SHALL implement states IDLE, LEARN, REMAP; IDLE->LEARN and REMAP->LEARN when BIST_EN=1; LEARN->REMAP when BIST_EN=0 and FAULT_COUNT>0; LEARN->IDLE when BIST_EN=0 and FAULT_COUNT=0.
REQ-007 SHALL drive FLT_READY=1 exactly in LEARN (Moore, registered state); a report is accepted on an edge where FLT_VALID=1 and FLT_READY=1.
REQ-008 SHALL, on accept, drop the report with no state change if FLT_ADDR equals any valid entry address (duplicate suppression).
REQ-009 SHALL, on accept of a new address with FAULT_COUNT<NUM_SPARE, write entry[FAULT_COUNT], set its valid, increment FAULT_COUNT by 1; the entry is visible to duplicate check and lookup next cycle.
REQ-010 SHALL, on accept of a new address with FAULT_COUNT=NUM_SPARE, set REPAIR_FAIL and drop the report; FAULT_COUNT never exceeds NUM_SPARE or wraps.
REQ-011 SHALL retain table contents across LEARN->REMAP->LEARN; re-entering LEARN appends.
REQ-012 SHALL, on CLEAR=1 in any state, invalidate all entries, zero FAULT_COUNT, clear REPAIR_FAIL, go IDLE; CLEAR overrides a same-cycle fault accept and a same-cycle lookup.
REQ-013 SHALL compare ADDR against all valid entries in parallel; a hit requires state REMAP and CSB=0; on multiple matches lowest index wins.
REQ-014 SHALL, on hit, register on the next edge: BISR_EN=1, SPARE_CSB=0, SPARE_WEB=WEB, SPARE_ADDR=hit index, SPARE_IDATA=IDATA if WEB=0 else 0; latency exactly 1 cycle.
REQ-015 SHALL, on miss, CSB=1, or state not REMAP, register idle outputs: BISR_EN=0, SPARE_CSB=1, SPARE_WEB=1, SPARE_ADDR=0, SPARE_IDATA=0.
REQ-016 SHALL support back-to-back host accesses every cycle with no stall; lookup never alters table or counters.

Reset
REQ-017 SHALL, while RST=1, asynchronously force state IDLE, all entries invalid, FAULT_COUNT=0, REPAIR_FAIL=0, FLT_READY=0, and idle output values of REQ-015.
REQ-018 SHALL, on RST asserted mid-LEARN or mid-access, abort with no partial entry retained; first fault accepted no earlier than one cycle after BIST_EN=1 following RST deassertion.

Verification (NUM_SPARE=4, ADDR_W=16, DATA_W=8)
REQ-019 SHALL cover learn: BIST_EN=1, report 0x0010, 0x0020, 0x0010 -> FAULT_COUNT=2, REPAIR_FAIL=0.
REQ-020 SHALL cover remap write/read: after REQ-019, BIST_EN=0, CSB=0 WEB=0 ADDR=0x0020 IDATA=0xA5 -> next cycle BISR_EN=1, SPARE_ADDR=1, SPARE_WEB=0, SPARE_IDATA=0xA5; then WEB=1 same ADDR -> SPARE_WEB=1, SPARE_IDATA=0.
REQ-021 SHALL cover overflow: report 5 unique addresses -> FAULT_COUNT=4, REPAIR_FAIL=1, fifth address misses in REMAP.
REQ-022 SHALL cover miss/deselect: ADDR=0x0030 or CSB=1 in REMAP -> BISR_EN=0, SPARE_CSB=1.
REQ-023 SHALL cover CLEAR and RST: CLEAR in REMAP -> FAULT_COUNT=0, state IDLE, ADDR=0x0010 misses; RST mid-LEARN -> all outputs idle within same cycle.

Source files
------------

// File: rtl/bisr_remap_ctrl.sv
// ---------------------------------------------------------------------------
// bisr_remap_ctrl
//
// Built-in self-repair remap controller. During a BIST learn window it
// collects unique faulty row addresses into a small table. Entry i always
// maps to spare row i. Afterwards, in REMAP, host accesses whose address
// matches a learned fault are redirected to the spare array with a fixed
// one-cycle registered latency.
//
// Ports
//   CLK          in   clock, all state on rising edge
//   RST          in   asynchronous active-high reset
//   BIST_EN      in   learn window (BIST reporting faults)
//   FLT_VALID    in   fault report valid
//   FLT_ADDR     in   faulty host address              [ADDR_W]
//   FLT_READY    out  fault report accepted (high only in LEARN)
//   CLEAR        in   synchronous fault-table wipe
//   CSB          in   host chip select, active-low
//   WEB          in   host write enable, active-low
//   ADDR         in   host address                     [ADDR_W]
//   IDATA        in   host write data                  [DATA_W]
//   BISR_EN      out  registered hit: use spare data
//   SPARE_CSB    out  spare select, active-low
//   SPARE_WEB    out  spare write enable, active-low
//   SPARE_ADDR   out  spare row index                  [SW]
//   SPARE_IDATA  out  spare write data                 [DATA_W]
//   FAULT_COUNT  out  number of valid table entries    [CW]
//   REPAIR_FAIL  out  sticky: more unique faults than spares
// ---------------------------------------------------------------------------
module bisr_remap_ctrl #(
  parameter  int ADDR_W    = 16,
  parameter  int DATA_W    = 8,
  parameter  int NUM_SPARE = 32,
  localparam int SW        = $clog2(NUM_SPARE),
  localparam int CW        = $clog2(NUM_SPARE + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              BIST_EN,
  input  logic              FLT_VALID,
  input  logic [ADDR_W-1:0] FLT_ADDR,
  output logic              FLT_READY,
  input  logic              CLEAR,
  input  logic              CSB,
  input  logic              WEB,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] IDATA,
  output logic              BISR_EN,
  output logic              SPARE_CSB,
  output logic              SPARE_WEB,
  output logic [SW-1:0]     SPARE_ADDR,
  output logic [DATA_W-1:0] SPARE_IDATA,
  output logic [CW-1:0]     FAULT_COUNT,
  output logic              REPAIR_FAIL
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEARN = 2'd1,
    REMAP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Fault table: valid bits carry reset, addresses are plain storage.
  logic [NUM_SPARE-1:0] r_valid;
  logic [ADDR_W-1:0]    r_addr [NUM_SPARE];
  logic [CW-1:0]        r_count;
  logic                 r_fail;

  // Registered spare-side outputs.
  logic                 r_bisr_en;
  logic                 r_spare_csb;
  logic                 r_spare_web;
  logic [SW-1:0]        r_spare_addr;
  logic [DATA_W-1:0]    r_spare_idata;

  logic [NUM_SPARE-1:0] w_flt_match;
  logic [NUM_SPARE-1:0] w_host_match;
  logic [NUM_SPARE-1:0] w_wr_sel;
  logic                 w_dup;
  logic                 w_full;
  logic                 w_accept;
  logic                 w_new;
  logic                 w_overflow;
  logic                 w_hit;
  logic [SW-1:0]        w_hit_idx;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    if (CLEAR) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (BIST_EN) w_state_next = LEARN;
        LEARN:   if (!BIST_EN) w_state_next = (r_count != '0) ? REMAP : IDLE;
        REMAP:   if (BIST_EN) w_state_next = LEARN;
        default: w_state_next = IDLE;
      endcase
    end
  end

  assign FLT_READY = (r_state == LEARN);

  // -------------------------------------------------------------------------
  // Parallel match against all valid entries (fault side and host side)
  // -------------------------------------------------------------------------
  always_comb begin
    w_flt_match  = '0;
    w_host_match = '0;
    for (int i = 0; i < NUM_SPARE; i++) begin
      w_flt_match[i]  = r_valid[i] && (r_addr[i] == FLT_ADDR);
      w_host_match[i] = r_valid[i] && (r_addr[i] == ADDR);
    end
  end

  // Lowest matching index wins: scan downward so the last write is the lowest.
  always_comb begin
    w_hit_idx = '0;
    for (int i = NUM_SPARE - 1; i >= 0; i--) begin
      if (w_host_match[i]) w_hit_idx = SW'(i);
    end
  end

  assign w_dup      = |w_flt_match;
  assign w_full     = (r_count == CW'(NUM_SPARE));
  assign w_accept   = FLT_VALID && FLT_READY && !CLEAR;
  assign w_new      = w_accept && !w_dup && !w_full;
  assign w_overflow = w_accept && !w_dup && w_full;
  assign w_hit      = (r_state == REMAP) && !CSB && (|w_host_match) && !CLEAR;

  // New faults append at the slot addressed by the current count.
  always_comb begin
    w_wr_sel = '0;
    for (int i = 0; i < NUM_SPARE; i++) begin
      w_wr_sel[i] = w_new && (r_count == CW'(i));
    end
  end

  // -------------------------------------------------------------------------
  // Table control: valid bits, count, sticky fail
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_valid <= '0;
      r_count <= '0;
      r_fail  <= 1'b0;
    end else if (CLEAR) begin
      r_valid <= '0;
      r_count <= '0;
      r_fail  <= 1'b0;
    end else begin
      if (w_new) begin
        r_valid <= r_valid | w_wr_sel;
        r_count <= r_count + CW'(1);
      end
      if (w_overflow) r_fail <= 1'b1;
    end
  end

  // NOTE: the address storage is deliberately not reset; an entry is only
  // observable through its valid bit, which is reset, so stale addresses are
  // harmless and the array stays plain storage.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_SPARE; i++) begin
      if (w_wr_sel[i]) r_addr[i] <= FLT_ADDR;
    end
  end

  // -------------------------------------------------------------------------
  // Registered spare-array drive, one cycle after the host access
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_bisr_en     <= 1'b0;
      r_spare_csb   <= 1'b1;
      r_spare_web   <= 1'b1;
      r_spare_addr  <= '0;
      r_spare_idata <= '0;
    end else if (w_hit) begin
      r_bisr_en     <= 1'b1;
      r_spare_csb   <= 1'b0;
      r_spare_web   <= WEB;
      r_spare_addr  <= w_hit_idx;
      r_spare_idata <= WEB ? '0 : IDATA;
    end else begin
      r_bisr_en     <= 1'b0;
      r_spare_csb   <= 1'b1;
      r_spare_web   <= 1'b1;
      r_spare_addr  <= '0;
      r_spare_idata <= '0;
    end
  end

  assign BISR_EN     = r_bisr_en;
  assign SPARE_CSB   = r_spare_csb;
  assign SPARE_WEB   = r_spare_web;
  assign SPARE_ADDR  = r_spare_addr;
  assign SPARE_IDATA = r_spare_idata;
  assign FAULT_COUNT = r_count;
  assign REPAIR_FAIL = r_fail;

endmodule

// File: tb/tb_bisr_remap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bisr_remap_ctrl
//
// Self-checking bench for bisr_remap_ctrl with NUM_SPARE=4, ADDR_W=16,
// DATA_W=8. A reference model keeps the fault table as a queue of addresses
// (queue position == spare row) and predicts every registered output after
// each clock edge. Directed scenarios come first, then randomized traffic.
// ---------------------------------------------------------------------------
module tb_bisr_remap_ctrl;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int NS = 4;
  localparam int SW = $clog2(NS);
  localparam int CW = $clog2(NS + 1);

  localparam int M_IDLE  = 0;
  localparam int M_LEARN = 1;
  localparam int M_REMAP = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic          BIST_EN;
  logic          FLT_VALID;
  logic [AW-1:0] FLT_ADDR;
  logic          FLT_READY;
  logic          CLEAR;
  logic          CSB;
  logic          WEB;
  logic [AW-1:0] ADDR;
  logic [DW-1:0] IDATA;
  logic          BISR_EN;
  logic          SPARE_CSB;
  logic          SPARE_WEB;
  logic [SW-1:0] SPARE_ADDR;
  logic [DW-1:0] SPARE_IDATA;
  logic [CW-1:0] FAULT_COUNT;
  logic          REPAIR_FAIL;

  bisr_remap_ctrl #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .NUM_SPARE(NS)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .BIST_EN    (BIST_EN),
    .FLT_VALID  (FLT_VALID),
    .FLT_ADDR   (FLT_ADDR),
    .FLT_READY  (FLT_READY),
    .CLEAR      (CLEAR),
    .CSB        (CSB),
    .WEB        (WEB),
    .ADDR       (ADDR),
    .IDATA      (IDATA),
    .BISR_EN    (BISR_EN),
    .SPARE_CSB  (SPARE_CSB),
    .SPARE_WEB  (SPARE_WEB),
    .SPARE_ADDR (SPARE_ADDR),
    .SPARE_IDATA(SPARE_IDATA),
    .FAULT_COUNT(FAULT_COUNT),
    .REPAIR_FAIL(REPAIR_FAIL)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [AW-1:0] m_tab [$];
  int            m_mode;
  bit            m_fail;
  logic [31:0]   e_bisr, e_scsb, e_sweb, e_saddr, e_sidata;

  logic [AW-1:0] pool [8] = '{16'h0010, 16'h0020, 16'h0030, 16'h0040,
                              16'h1234, 16'hBEEF, 16'h0000, 16'hFFFF};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_idle_outs();
    e_bisr   = 0;
    e_scsb   = 1;
    e_sweb   = 1;
    e_saddr  = 0;
    e_sidata = 0;
  endtask

  task automatic model_reset();
    m_tab.delete();
    m_mode = M_IDLE;
    m_fail = 0;
    model_idle_outs();
  endtask

  // Predict the effect of the coming rising edge from the current inputs.
  task automatic model_edge();
    automatic int  old_cnt = m_tab.size();
    automatic int  hit     = -1;
    automatic bit  found   = 0;
    if (CLEAR) begin
      model_reset();
      return;
    end
    if (m_mode == M_REMAP && !CSB) begin
      foreach (m_tab[i]) if (hit < 0 && m_tab[i] == ADDR) hit = i;
    end
    if (hit >= 0) begin
      e_bisr   = 1;
      e_scsb   = 0;
      e_sweb   = 32'(WEB);
      e_saddr  = hit;
      e_sidata = WEB ? 0 : 32'(IDATA);
    end else begin
      model_idle_outs();
    end
    if (m_mode == M_LEARN && FLT_VALID) begin
      foreach (m_tab[i]) if (m_tab[i] == FLT_ADDR) found = 1;
      if (!found) begin
        if (m_tab.size() < NS) m_tab.push_back(FLT_ADDR);
        else                   m_fail = 1;
      end
    end
    case (m_mode)
      M_IDLE:  if (BIST_EN) m_mode = M_LEARN;
      M_LEARN: if (!BIST_EN) m_mode = (old_cnt > 0) ? M_REMAP : M_IDLE;
      default: if (BIST_EN) m_mode = M_LEARN;
    endcase
  endtask

  task automatic compare_all();
    check("flt_ready",   32'(FLT_READY),   (m_mode == M_LEARN) ? 1 : 0);
    check("fault_count", 32'(FAULT_COUNT), m_tab.size());
    check("repair_fail", 32'(REPAIR_FAIL), 32'(m_fail));
    check("bisr_en",     32'(BISR_EN),     e_bisr);
    check("spare_csb",   32'(SPARE_CSB),   e_scsb);
    check("spare_web",   32'(SPARE_WEB),   e_sweb);
    check("spare_addr",  32'(SPARE_ADDR),  e_saddr);
    check("spare_idata", 32'(SPARE_IDATA), e_sidata);
  endtask

  // Inputs are stable since the last step; outputs sampled 1 ns after edge.
  task automatic step();
    model_edge();
    @(posedge CLK);
    #1;
    compare_all();
  endtask

  task automatic report(input logic [AW-1:0] a);
    FLT_VALID = 1;
    FLT_ADDR  = a;
    step();
  endtask

  initial begin
    RST       = 1;
    BIST_EN   = 0;
    FLT_VALID = 0;
    FLT_ADDR  = '0;
    CLEAR     = 0;
    CSB       = 1;
    WEB       = 1;
    ADDR      = '0;
    IDATA     = '0;
    model_reset();

    // Reset state observed while RST is held.
    #12;
    compare_all();
    #1 RST = 0;
    step();

    // Learn with a duplicate report.
    BIST_EN = 1;
    step();
    report(16'h0010);
    report(16'h0020);
    report(16'h0010);
    FLT_VALID = 0;
    step();
    check("learn_count", 32'(FAULT_COUNT), 2);
    check("learn_fail",  32'(REPAIR_FAIL), 0);

    // Remap write then read of the second learned address.
    BIST_EN = 0;
    step();
    CSB = 0; WEB = 0; ADDR = 16'h0020; IDATA = 8'hA5;
    step();
    check("wr_bisr_en",  32'(BISR_EN),     1);
    check("wr_addr",     32'(SPARE_ADDR),  1);
    check("wr_web",      32'(SPARE_WEB),   0);
    check("wr_idata",    32'(SPARE_IDATA), 32'h0000_00A5);
    WEB = 1;
    step();
    check("rd_web",      32'(SPARE_WEB),   1);
    check("rd_idata",    32'(SPARE_IDATA), 0);

    // Miss and deselect.
    ADDR = 16'h0030;
    step();
    check("miss_bisr",   32'(BISR_EN),     0);
    check("miss_csb",    32'(SPARE_CSB),   1);
    CSB = 1; ADDR = 16'h0020;
    step();
    check("desel_bisr",  32'(BISR_EN),     0);

    // CLEAR in REMAP, then a former fault address must miss.
    CLEAR = 1;
    step();
    CLEAR = 0;
    check("clr_count",   32'(FAULT_COUNT), 0);
    CSB = 0; ADDR = 16'h0010;
    step();
    check("clr_miss",    32'(BISR_EN),     0);
    CSB = 1;

    // Overflow: five unique faults into four spares.
    BIST_EN = 1;
    step();
    for (int k = 0; k < 5; k++) report(16'h0100 + 16'(k));
    FLT_VALID = 0;
    BIST_EN   = 0;
    step();
    check("ovf_count",   32'(FAULT_COUNT), 4);
    check("ovf_fail",    32'(REPAIR_FAIL), 1);
    CSB = 0; WEB = 1; ADDR = 16'h0104;
    step();
    check("ovf_5th_miss", 32'(BISR_EN),    0);
    ADDR = 16'h0103;
    step();
    check("ovf_4th_hit", 32'(SPARE_ADDR),  3);
    CSB = 1;

    // Asynchronous reset mid-LEARN with a report in flight.
    CLEAR = 1;
    step();
    CLEAR = 0;
    BIST_EN = 1;
    step();
    report(16'h0300);
    FLT_ADDR = 16'h0301;
    #2 RST = 1;
    model_reset();
    #1;
    compare_all();
    @(posedge CLK);
    #1;
    compare_all();
    BIST_EN = 0; FLT_VALID = 0;
    #2 RST = 0;
    step();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(15) == 0) BIST_EN = ~BIST_EN;
      FLT_VALID = 1'($urandom_range(1));
      FLT_ADDR  = pool[$urandom_range(7)];
      CSB       = 1'($urandom_range(1));
      WEB       = 1'($urandom_range(1));
      ADDR      = pool[$urandom_range(7)];
      IDATA     = 8'($urandom);
      CLEAR     = ($urandom_range(99) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
